// File: rtl/dht11_pkg.sv
// dht11_pkg: shared header for the DHT11 start stage and receiver.
//   - receiver FSM state encoding
//   - default microsecond timing constants for both stages
//   - frame length and byte positions within the 40-bit frame
//   - checksum helper (the sum of the four data bytes, mod 256)
package dht11_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WAIT_LOW  = 3'd1,
    ST_MEAS_LOW  = 3'd2,
    ST_MEAS_HIGH = 3'd3,
    ST_CHECK     = 3'd4,
    ST_DONE      = 3'd5
  } dht11_state_t;

  // Receiver timing (us)
  localparam int unsigned DHT11_PREAMBLE_US      = 50;
  localparam int unsigned DHT11_BIT_THRESHOLD_US = 40;
  localparam int unsigned DHT11_TIMEOUT_US       = 200;

  // Start-stage timing (us)
  localparam int unsigned DHT11_START_LOW_US     = 18000;
  localparam int unsigned DHT11_START_RELEASE_US = 30;
  localparam int unsigned DHT11_START_RESP_US    = 160;

  // Frame layout, first byte on the wire is byte 0 (MSB first)
  localparam int unsigned DHT11_FRAME_BITS    = 40;
  localparam int unsigned DHT11_BYTE_HUM_INT  = 0;
  localparam int unsigned DHT11_BYTE_HUM_DEC  = 1;
  localparam int unsigned DHT11_BYTE_TEMP_INT = 2;
  localparam int unsigned DHT11_BYTE_TEMP_DEC = 3;
  localparam int unsigned DHT11_BYTE_CHECKSUM = 4;

  function automatic logic [7:0] dht11_byte(input logic [39:0] frame,
                                            input int unsigned idx);
    logic [39:0] sh;
    sh = frame >> (8 * (4 - idx));
    return sh[7:0];
  endfunction

  // 8-bit sum, carry discarded
  function automatic logic [7:0] dht11_checksum(input logic [39:0] frame);
    return dht11_byte(frame, DHT11_BYTE_HUM_INT)  + dht11_byte(frame, DHT11_BYTE_HUM_DEC) +
           dht11_byte(frame, DHT11_BYTE_TEMP_INT) + dht11_byte(frame, DHT11_BYTE_TEMP_DEC);
  endfunction

endpackage

// File: rtl/dht11_edge_sync.sv
// dht11_edge_sync: 2-FF synchronizer for an asynchronous pad plus a
// previous-value flop for edge detection.
// Ports:
//   clk, rst  : clock, synchronous active-high reset
//   din       : asynchronous pad input
//   sync      : synchronized level
//   rise/fall : one-cycle pulses on synchronized edges
// All three flops reset to RESET_VAL (bus idle level) so no edge is seen
// when reset is released on an idle line.
module dht11_edge_sync #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic sync,
  output logic rise,
  output logic fall
);

  logic meta_q;
  logic sync_q;
  logic prev_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
      prev_q <= RESET_VAL;
    end else begin
      meta_q <= din;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign sync = sync_q;
  assign rise = sync_q & ~prev_q;
  assign fall = ~sync_q & prev_q;

endmodule

// File: rtl/dht11_receiver.sv
// dht11_receiver: decodes the 40-bit DHT11 data frame after the start stage
// releases the bus. Each bit's high width is measured and compared against
// BIT_THRESHOLD; the four data bytes are published with a one-cycle valid.
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   start           : start-stage handover level (sampled in IDLE only)
//   data_in         : raw asynchronous sensor line (input only)
//   humidity_int/dec, temp_int/dec : last accepted frame bytes
//   valid           : one-cycle pulse when the bytes update
//   checksum_err    : one-cycle pulse on checksum mismatch
//   timeout_err     : one-cycle pulse when a phase exceeds TIMEOUT_US
//   busy            : high whenever the FSM is outside IDLE
// Build option: define DHT11_CHECKSUM_EN to verify the checksum byte;
// when undefined every complete frame is accepted and checksum_err is 0.
module dht11_receiver
  import dht11_pkg::*;
#(
  parameter int unsigned CLK_PER_US    = 1,
  parameter int unsigned BIT_THRESHOLD = DHT11_BIT_THRESHOLD_US,
  parameter int unsigned TIMEOUT_US    = DHT11_TIMEOUT_US
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       data_in,
  output logic [7:0] humidity_int,
  output logic [7:0] humidity_dec,
  output logic [7:0] temp_int,
  output logic [7:0] temp_dec,
  output logic       valid,
  output logic       checksum_err,
  output logic       timeout_err,
  output logic       busy
);

  localparam int unsigned   TO_CYC   = TIMEOUT_US * CLK_PER_US;
  localparam int unsigned   CW       = $clog2(TO_CYC + 2);
  localparam logic [CW-1:0] TO_LIM   = CW'(TO_CYC);
  localparam logic [CW:0]   THR      = (CW+1)'(BIT_THRESHOLD * CLK_PER_US);
  localparam logic [5:0]    LAST_BIT = 6'(DHT11_FRAME_BITS - 1);

  dht11_state_t state, state_nxt;

  logic          line_s, line_rise, line_fall;
  logic [CW-1:0] cnt;
  logic [5:0]    bit_idx;
  logic [39:0]   shreg;

  logic phase_over;
  logic bit_val;
  logic shift_en;
  logic to_hit;
  logic load_out;

  dht11_edge_sync #(
    .RESET_VAL(1'b1)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .din (data_in),
    .sync(line_s),
    .rise(line_rise),
    .fall(line_fall)
  );

  assign phase_over = (cnt > TO_LIM);

  // The counter is cleared on the rising edge and reads w-1 in the cycle the
  // falling edge is seen for a w-cycle pulse; +1 recovers the full width.
  assign bit_val = (({1'b0, cnt} + (CW+1)'(1)) > THR);

`ifdef DHT11_CHECKSUM_EN
  logic csum_ok;
  logic ck_bad;
  assign csum_ok = (dht11_checksum(shreg) == dht11_byte(shreg, DHT11_BYTE_CHECKSUM));
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    shift_en  = 1'b0;
    to_hit    = 1'b0;
    load_out  = 1'b0;
`ifdef DHT11_CHECKSUM_EN
    ck_bad    = 1'b0;
`endif
    case (state)
      ST_IDLE: begin
        if (start) state_nxt = ST_WAIT_LOW;
      end
      ST_WAIT_LOW: begin
        if (phase_over) begin
          to_hit    = 1'b1;
          state_nxt = ST_IDLE;
        end else if (!line_s) begin
          state_nxt = ST_MEAS_LOW;
        end
      end
      ST_MEAS_LOW: begin
        if (phase_over) begin
          to_hit    = 1'b1;
          state_nxt = ST_IDLE;
        end else if (line_rise) begin
          state_nxt = ST_MEAS_HIGH;
        end
      end
      ST_MEAS_HIGH: begin
        if (phase_over) begin
          to_hit    = 1'b1;
          state_nxt = ST_IDLE;
        end else if (line_fall) begin
          shift_en  = 1'b1;
          state_nxt = (bit_idx == LAST_BIT) ? ST_CHECK : ST_MEAS_LOW;
        end
      end
      ST_CHECK: begin
`ifdef DHT11_CHECKSUM_EN
        if (csum_ok) begin
          state_nxt = ST_DONE;
          load_out  = 1'b1;
        end else begin
          state_nxt = ST_IDLE;
          ck_bad    = 1'b1;
        end
`else
        state_nxt = ST_DONE;
        load_out  = 1'b1;
`endif
      end
      ST_DONE: begin
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // Outputs are loaded on the CHECK->DONE edge so the bytes and valid both
  // appear in the DONE cycle, two cycles after the last falling edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt          <= '0;
      bit_idx      <= '0;
      shreg        <= '0;
      humidity_int <= '0;
      humidity_dec <= '0;
      temp_int     <= '0;
      temp_dec     <= '0;
      valid        <= 1'b0;
      timeout_err  <= 1'b0;
    end else begin
      valid       <= load_out;
      timeout_err <= to_hit;

      if ((state_nxt != state) || line_rise || line_fall) cnt <= '0;
      else if (cnt != '1)                                 cnt <= cnt + CW'(1);

      if (state == ST_WAIT_LOW) begin
        bit_idx <= '0;
        shreg   <= '0;
      end else if (shift_en) begin
        shreg   <= {shreg[38:0], bit_val};
        bit_idx <= bit_idx + 6'd1;
      end

      if (load_out) begin
        humidity_int <= dht11_byte(shreg, DHT11_BYTE_HUM_INT);
        humidity_dec <= dht11_byte(shreg, DHT11_BYTE_HUM_DEC);
        temp_int     <= dht11_byte(shreg, DHT11_BYTE_TEMP_INT);
        temp_dec     <= dht11_byte(shreg, DHT11_BYTE_TEMP_DEC);
      end
    end
  end

`ifdef DHT11_CHECKSUM_EN
  logic ck_err_q;
  always_ff @(posedge clk) begin
    if (rst) ck_err_q <= 1'b0;
    else     ck_err_q <= ck_bad;
  end
  assign checksum_err = ck_err_q;
`else
  assign checksum_err = 1'b0;
`endif

  assign busy = (state != ST_IDLE);

endmodule

// File: tb/tb_dht11_receiver.sv
module tb_dht11_receiver;

  localparam int THRESH = 40;
`ifdef DHT11_CHECKSUM_EN
  localparam bit CK_EN = 1'b1;
`else
  localparam bit CK_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       data_in;
  logic [7:0] humidity_int, humidity_dec, temp_int, temp_dec;
  logic       valid, checksum_err, timeout_err, busy;

  always #5 clk = ~clk;

  dht11_receiver #(
    .CLK_PER_US   (1),
    .BIT_THRESHOLD(40),
    .TIMEOUT_US   (200)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .data_in     (data_in),
    .humidity_int(humidity_int),
    .humidity_dec(humidity_dec),
    .temp_int    (temp_int),
    .temp_dec    (temp_dec),
    .valid       (valid),
    .checksum_err(checksum_err),
    .timeout_err (timeout_err),
    .busy        (busy)
  );

  // kind: 0 = valid, 1 = checksum error, 2 = timeout
  typedef struct {
    int          kind;
    logic [31:0] bytes;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] model_out = '0;

  task automatic chk(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  function automatic logic [39:0] mkframe(input logic [7:0] a, input logic [7:0] b,
                                          input logic [7:0] c, input logic [7:0] d);
    logic [7:0] s;
    s = a + b + c + d;
    return {a, b, c, d, s};
  endfunction

  // Monitor: pops the scoreboard whenever the DUT reports an event
  always @(negedge clk) begin : mon
    exp_t e;
    int   kind;
    if (!rst && (valid || checksum_err || timeout_err)) begin
      kind = valid ? 0 : (checksum_err ? 1 : 2);
      chk("event_exclusive", $countones({valid, checksum_err, timeout_err}), 1);
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_event: got kind %0d expected none", kind);
      end else begin
        e = sb.pop_front();
        chk("event_kind", kind, e.kind);
        chk("out_bytes", {humidity_int, humidity_dec, temp_int, temp_dec}, e.bytes);
        chk("busy_at_event", busy, (kind == 0) ? 1 : 0);
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Drives one frame; mode 0 nominal 26/70 us, 1 boundary 40/41 us, 2 random.
  // abort_after >= 0 stops right after that bit's falling edge (no event).
  task automatic send_frame(input logic [39:0] frame, input int mode,
                            input int abort_after, input int toggle_bit);
    int w[40];
    int vals[5];
    int pre;
    for (int i = 0; i < 40; i++) begin
      case (mode)
        0:       w[i] = frame[39-i] ? 70 : 26;
        1:       w[i] = frame[39-i] ? 41 : 40;
        default: w[i] = frame[39-i] ? int'($urandom_range(41, 80)) : int'($urandom_range(15, 40));
      endcase
    end
    for (int k = 0; k < 5; k++) begin
      vals[k] = 0;
      for (int j = 0; j < 8; j++) vals[k] = vals[k] * 2 + ((w[8*k+j] > THRESH) ? 1 : 0);
    end
    if (abort_after < 0) begin
      if (CK_EN && (((vals[0] + vals[1] + vals[2] + vals[3]) % 256) != vals[4])) begin
        sb.push_back('{kind: 1, bytes: model_out});
      end else begin
        model_out = {vals[0][7:0], vals[1][7:0], vals[2][7:0], vals[3][7:0]};
        sb.push_back('{kind: 0, bytes: model_out});
      end
    end
    @(negedge clk);
    start   = 1'b1;
    data_in = 1'b0;
    for (int i = 0; i < 40; i++) begin
      pre = (mode == 2) ? int'($urandom_range(40, 60)) : 50;
      idle(pre);
      data_in = 1'b1;
      for (int j = 0; j < w[i]; j++) begin
        if (i == toggle_bit && j == 5) start = 1'b0;
        if (i == toggle_bit && j == 9) start = 1'b1;
        @(negedge clk);
      end
      data_in = 1'b0;
      if (i == abort_after) return;
      if (i == 39) start = 1'b0;
    end
    idle(50);
    data_in = 1'b1;
  endtask

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while (sb.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("pending_events", sb.size(), 0);
    sb.delete();
    idle(20);
  endtask

  initial begin
    logic [39:0] f;
    rst     = 1'b1;
    start   = 1'b0;
    data_in = 1'b1;
    idle(3);
    chk("reset_busy", busy, 0);
    chk("reset_valid", valid, 0);
    chk("reset_cksum_err", checksum_err, 0);
    chk("reset_timeout_err", timeout_err, 0);
    chk("reset_bytes", {humidity_int, humidity_dec, temp_int, temp_dec}, 0);
    rst = 1'b0;
    idle(5);

    // Reference frame and its corrupted-checksum twin
    send_frame(40'h2D_00_17_00_44, 0, -1, -1);
    wait_drain(300);
    chk("ref_frame_bytes", {humidity_int, humidity_dec, temp_int, temp_dec}, 32'h2D001700);
    send_frame(40'h2D_00_17_00_45, 0, -1, -1);
    wait_drain(300);

    // 40 us decodes as 0, 41 us as 1
    send_frame(mkframe(8'hA5, 8'h3C, 8'h0F, 8'hF0), 1, -1, -1);
    wait_drain(300);

    // Line held high: timeout after 201 us in WAIT_LOW
    sb.push_back('{kind: 2, bytes: model_out});
    @(negedge clk);
    start   = 1'b1;
    data_in = 1'b1;
    idle(3);
    start = 1'b0;
    wait_drain(400);
    chk("busy_after_timeout", busy, 0);

    // Reset mid-frame after bit 20
    send_frame(mkframe(8'h33, 8'h01, 8'h19, 8'h02), 0, 20, -1);
    rst     = 1'b1;
    start   = 1'b0;
    data_in = 1'b1;
    @(negedge clk);
    chk("midreset_busy", busy, 0);
    chk("midreset_flags", {valid, checksum_err, timeout_err}, 0);
    chk("midreset_bytes", {humidity_int, humidity_dec, temp_int, temp_dec}, 0);
    rst       = 1'b0;
    model_out = '0;
    idle(10);
    send_frame(mkframe(8'h3C, 8'h05, 8'h1A, 8'h07), 0, -1, -1);
    wait_drain(300);

    // start toggled during bit 10 is ignored
    send_frame(mkframe(8'h28, 8'h00, 8'h15, 8'h03), 0, -1, 10);
    wait_drain(300);

    // Random frames with random widths; some carry a bad checksum
    for (int r = 0; r < 6; r++) begin
      f = mkframe(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
      if ($urandom_range(0, 3) == 0) f[7:0] = f[7:0] + 8'd1;
      send_frame(f, 2, -1, -1);
      wait_drain(300);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dht11_receiver.md
# dht11_receiver

Decodes the 40-bit DHT11 data frame from the single-wire sensor line once the start stage has handed over the bus. It sits directly downstream of the start/handshake stage and consumes that stage's confirm-to-receiver level as its `start` input. It measures each bit's high-pulse width on a 1 MHz tick, assembles humidity and temperature bytes, verifies the checksum and publishes the results with a one-cycle valid strobe.

## Interface
- `CLK_PER_US`, 1: clock cycles per microsecond; all counts below are in microseconds multiplied by this value.
- `BIT_THRESHOLD`, 40: a high pulse of more than this many µs decodes as 1; this many µs or fewer decodes as 0.
- `TIMEOUT_US`, 200: maximum duration of any single low or high phase before the frame is aborted.
- `clk`  in  1  system clock (1 MHz nominal).
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  level from the start stage; high means the sensor response is done and the bus is released.
- `data_in`  in  1  raw sensor line (asynchronous); read-only, never driven by this block.
- `humidity_int`, `humidity_dec`, `temp_int`, `temp_dec`  out  8 each  last accepted frame bytes.
- `valid`  out  1  one-cycle pulse when the output bytes update.
- `checksum_err`  out  1  one-cycle pulse when a checksum mismatch occurs.
- `timeout_err`  out  1  one-cycle pulse when a frame is aborted.
- `busy`  out  1  high in every state except IDLE.

## Operation
- `data_in` passes through a 2-FF synchronizer, then a registered previous-value flop that provides rise and fall detection.
- States:
  - IDLE: leave when `start` is sampled high.
  - WAIT_LOW: wait for the line to be low.
  - MEAS_LOW: measure the ~50 µs bit preamble.
  - MEAS_HIGH: count the high width.
  - CHECK
  - DONE
- IDLE -> WAIT_LOW on `start`=1. WAIT_LOW -> MEAS_LOW when the synced line is 0. MEAS_LOW -> MEAS_HIGH on a rising edge. MEAS_HIGH -> MEAS_LOW on a falling edge while the bit index is below 39; the bit is shifted in MSB-first. The falling edge that ends bit 39 goes to CHECK.
- CHECK -> DONE on checksum match. On mismatch, CHECK -> IDLE and `checksum_err` pulses. DONE -> IDLE, loading all four output bytes and pulsing `valid`.
- Bit decision: bit = 1 iff `high_count > BIT_THRESHOLD*CLK_PER_US`.
- Checksum: byte4 == (byte0+byte1+byte2+byte3) mod 256, computed at 8-bit width with carry discarded.
- Phase counter:
  - Cleared on every state change and every edge.
  - Saturates at its maximum value.
  - Width is the minimum that holds `TIMEOUT_US*CLK_PER_US+1`.
- Timeout: in WAIT_LOW, MEAS_LOW or MEAS_HIGH, a counter exceeding `TIMEOUT_US*CLK_PER_US` pulses `timeout_err` and returns to IDLE. The shift register is discarded and the outputs hold their previous values.
- `start` changes while `busy` are ignored. After returning to IDLE, a `start` still held high starts a new frame.
- Reset values: all output bytes 0x00; `valid`, `checksum_err`, `timeout_err`, `busy` all 0; state IDLE; synchronizer flops 1 (bus idle high).
- A reset mid-frame aborts the frame without an error pulse.

## Timing
- Synchronizer plus edge detect adds 3 cycles of latency from a pad edge to the state transition.
- `valid` asserts 2 cycles after the falling edge ending bit 39 is detected: one cycle in CHECK, then registered in DONE. The output bytes change in the same cycle `valid` is high.
- `valid`, `checksum_err` and `timeout_err` are mutually exclusive and each lasts exactly one cycle.
- `busy` rises the cycle after `start` is sampled and falls in the cycle the FSM re-enters IDLE.

## Configuration
- `DHT11_CHECKSUM_EN` defined: CHECK compares the checksum as described above.
- `DHT11_CHECKSUM_EN` undefined:
  - CHECK always proceeds to DONE.
  - `checksum_err` is tied to 0.
  - The adder is not synthesized.

## Structure
- Shared header `dht11_pkg`: state encodings, the default µs constants (50 µs preamble, 40 µs threshold, 200 µs timeout), frame length 40, and byte index constants.
- The start stage's 18000/30/160 µs constants move to the same header.
- Sub-module `dht11_edge_sync`: 2-FF synchronizer with rise/fall pulse outputs, reusable by the start stage.

## Test plan
- Frame bytes 0x2D,0x00,0x17,0x00 with checksum 0x44 (bit 0 = 26 µs high, bit 1 = 70 µs high) -> `valid` pulses once; outputs are 45, 0, 23, 0.
- Same frame with checksum 0x45 -> `checksum_err` pulses and the outputs keep their prior values. With the macro undefined -> `valid` pulses with bytes 45/0/23/0.
- High pulses of exactly 40 µs and 41 µs -> decode as 0 and 1 respectively.
- `start`=1 with the line held high for 201 µs -> `timeout_err` pulses, state returns to IDLE, `busy` drops.
- `rst` asserted after bit 20 -> the next cycle shows IDLE and all outputs 0. A following clean frame decodes correctly.
- `start` toggled during bit 10 of a valid frame -> no effect; the frame completes with a single `valid`.
